// File: rtl/i2c_slave_regbank_if.sv
// Byte-level handshake between an I2C slave core and the register bank behind it.
interface i2c_slave_regbank_if;
    logic       busy;
    logic       data_available;
    logic       data_request;
    logic [7:0] data_o;
    logic [7:0] data_i;

    // master: the I2C slave core that owns the bus-side byte stream
    modport master (
        output busy, data_available, data_request, data_o,
        input  data_i
    );

    // slave: the register bank consuming/serving those bytes
    modport slave (
        input  busy, data_available, data_request, data_o,
        output data_i
    );
endinterface

// File: rtl/i2c_slave_regbank.sv
// Register-bank adapter for an I2C slave byte interface: pointer byte, then
// auto-incrementing writes/reads over REG_COUNT 8-bit registers.

module i2c_regbank_cell #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [7:0] d,
    output logic [7:0] q,
    output logic       pulse
);
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= RESET_VAL;
            pulse <= 1'b0;
        end else begin
            pulse <= we;
            if (we) q <= d;
        end
    end
endmodule

module i2c_slave_regbank #(
    parameter int         REG_COUNT = 4,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        PW        = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    i2c_slave_regbank_if.slave     bus,
    output logic [8*REG_COUNT-1:0] regs_o,
    output logic [REG_COUNT-1:0]   wr_pulse,
    output logic                   rd_pulse,
    output logic [PW-1:0]          ptr_o
);
    typedef enum logic [1:0] {IDLE, PTR, DATA} state_t;

    // bit 0 = busy, bit 1 = data_available, bit 2 = data_request
    logic [2:0] sync1, sync2, hist;
    logic [2:0] rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            hist  <= '0;
        end else begin
            sync1 <= {bus.data_request, bus.data_available, bus.busy};
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;
    assign fall = ~sync2 & hist;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                wr_en;
    logic                rd_d;
    logic [REG_COUNT-1:0][7:0] regs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rd_pulse <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rd_pulse <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_en   = 1'b0;
        rd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise[0]) state_d = PTR;
            end
            PTR: begin
                // a pointer load takes precedence over a coincident read advance
                if (fall[2]) begin
                    rd_d  = 1'b1;
                    ptr_d = PW'(ptr_q + 1'b1);
                end
                if (rise[1]) begin
                    ptr_d   = bus.data_o[PW-1:0];
                    state_d = DATA;
                end
                if (fall[0]) state_d = IDLE;
            end
            DATA: begin
                wr_en = rise[1];
                rd_d  = fall[2];
                // write and read-consume in one cycle share a single advance
                if (rise[1] || fall[2]) ptr_d = PW'(ptr_q + 1'b1);
                if (fall[0]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < REG_COUNT; k++) begin : g_reg
        i2c_regbank_cell #(.RESET_VAL(RESET_VAL)) u_cell (
            .clk   (clk),
            .rst   (rst),
            .we    (wr_en && (ptr_q == PW'(k))),
            .d     (bus.data_o),
            .q     (regs_q[k]),
            .pulse (wr_pulse[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) bus.data_i <= RESET_VAL;
        else     bus.data_i <= regs_q[ptr_q];
    end

    assign regs_o = regs_q;
    assign ptr_o  = ptr_q;
endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
- Clocked register-bank adapter directly downstream of the I2C slave's byte interface (busy, data_available, data_request, data_o, data_i).
- Gives the slave addressable-register semantics. First byte written in a transaction sets the register pointer. Later written bytes land in consecutive registers. Read bytes are served from consecutive registers.
- Register contents go to board logic as a flat bus, with per-register update pulses.

Parameters:
- REG_COUNT, 4, number of 8-bit registers; power of 2, 2..16.
- RESET_VAL, 8'h00, reset value of every register.

Ports:
- clk, input, 1, system clock. All logic on posedge.
- rst, input, 1, synchronous active-high reset.
- busy, input, 1, from slave: high for the duration of an addressed transaction.
- data_available, input, 1, from slave: high while data_o holds a received byte.
- data_request, input, 1, from slave: high while the slave fetches a byte to transmit.
- data_o, input, 8, from slave: received byte.
- data_i, output, 8, to slave: byte to transmit.
- regs_o, output, 8*REG_COUNT, register contents; reg k at [8k+7:8k].
- wr_pulse, output, REG_COUNT, one-cycle pulse when reg k is written from I2C.
- rd_pulse, output, 1, one-cycle pulse when a read byte is consumed.
- ptr_o, output, clog2(REG_COUNT), current register pointer.

Behaviour:
- Slave signals may come from the SCL domain.
  - busy, data_available and data_request each pass through a 2-FF synchronizer.
  - Edge detection uses synchronizer output vs. its 1-cycle delayed copy.
  - data_o is sampled on the detected data_available rising edge; it must be stable while data_available is high.
- Reset (any cycle, including mid-transaction):
  - all registers = RESET_VAL, ptr = 0, state = IDLE.
  - data_i = RESET_VAL; wr_pulse = 0, rd_pulse = 0.
  - edge-detect history = 0, so a signal high at reset release is not an edge.
- FSM states: IDLE, PTR, DATA.
  - IDLE: busy rise -> PTR.
  - PTR: data_available rise -> ptr = data_o mod REG_COUNT (low bits only), -> DATA; no register write, no wr_pulse.
  - DATA: data_available rise -> reg[ptr] = data_o, wr_pulse[ptr] = 1 for one cycle, ptr = ptr+1 wrapping at REG_COUNT.
  - PTR or DATA: busy fall -> IDLE; ptr retained across transactions.
  - data_available rise while IDLE (should not occur): ignored.
- Reads (PTR or DATA):
  - data_i is registered and equals reg[ptr] from one cycle after any ptr or register change.
  - data_request fall -> ptr = ptr+1 (wrap), rd_pulse = 1 for one cycle.
  - Read with no pointer byte in the transaction reads from the retained ptr.
  - data_request fall while IDLE: ignored.
- Latency from raw input edge to effect:
  - 3 clk cycles to register write / ptr change.
  - 4 cycles to the data_i update.
- Simultaneous detected data_available rise and busy fall in the same cycle: the write/pointer action completes first, then state -> IDLE.
- Simultaneous detected data_available rise and data_request fall: write goes to the current ptr and ptr advances by 1 total, not 2. rd_pulse and wr_pulse both fire.
- Wrap-around: ptr = REG_COUNT-1, increment -> 0.
- regs_o is continuously driven from the register array; never tri-stated.

Test Plan:
- Reset, then idle 10 cycles -> regs_o = 0, data_i = 8'h00, ptr_o = 0, no pulses.
- Write transaction, bytes 8'h02, 8'hA5, 8'h3C (REG_COUNT=4):
  - ptr set to 2; reg2 = A5, reg3 = 3C.
  - wr_pulse = 4'b0100 then 4'b1000.
  - ptr_o = 0 after the wrap; busy fall -> IDLE.
- Write pointer 8'h07 (REG_COUNT=4) then bytes 11, 22 -> ptr = 3, reg3 = 11, reg0 = 22 (wrap).
- Read transaction with no pointer byte, regs {0:22, 1:00, 2:A5, 3:11}, ptr=1, three request pulses:
  - data_i sequence 00, A5, 11; three rd_pulse; ptr_o = 0.
- Assert rst mid-write after the pointer byte:
  - all regs = 0, state IDLE, ptr = 0.
  - next data_available rise without a new busy rise causes no write.
- Coincident data_available rise and busy fall in the same cycle -> byte still written, wr_pulse fires, FSM ends in IDLE.
